// File: rtl/rx_buffer_ctrl_module.sv
// rx_buffer_ctrl_module: byte FIFO between a receive stage and a transmit stage.
// Receive writes are taken on the rising edge of rx_done_sig. A three-state
// transmit FSM pops one byte per handshake with the transmit stage.
// Optional build macro RX_OVERFLOW_CNT_EN adds a saturating dropped-byte
// counter output, ovf_cnt.
module rx_buffer_ctrl_module #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_done_sig,
  output logic              rx_en_sig,
  output logic [7:0]        tx_data,
  output logic              tx_en_sig,
  input  logic              tx_done_sig,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow
`ifdef RX_OVERFLOW_CNT_EN
  ,
  output logic [7:0]        ovf_cnt
`endif
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                tx_en_d;
  logic [7:0]          tx_data_d;
  logic                pop;

  logic [7:0]          mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic                rx_done_q;
  logic                wr_pend;
  logic [7:0]          wr_byte;
  logic                rx_edge;
  logic                full;
  logic                do_wr;
  logic                drop;

  // Write-side decisions: a pop in the same cycle frees a slot for the write.
  always_comb begin
    rx_edge   = rx_done_sig & ~rx_done_q;
    full      = (fifo_count == CNT_W'(DEPTH));
    do_wr     = wr_pend & (~full | pop);
    drop      = wr_pend & full & ~pop;
    rx_en_sig = (fifo_count < CNT_W'(DEPTH));
  end

  // Edge detect, pending write, pointers, occupancy and sticky overflow.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      rx_done_q  <= 1'b0;
      wr_pend    <= 1'b0;
      wr_byte    <= 8'h00;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      rx_done_q <= rx_done_sig;
      wr_pend   <= rx_edge;
      if (rx_edge) begin
        wr_byte <= rx_data;
      end
      if (do_wr) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({do_wr, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage array; contents are never reset, only the pointers are.
  always_ff @(posedge sysclk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_byte;
    end
  end

  // Transmit FSM state and registered transmit outputs.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tx_en_sig <= 1'b0;
      tx_data   <= 8'h00;
    end else begin
      state_q   <= state_d;
      tx_en_sig <= tx_en_d;
      tx_data   <= tx_data_d;
    end
  end

  // Transmit FSM next-state: pop in LOAD, hold the byte until tx_done_sig.
  always_comb begin
    state_d   = state_q;
    tx_en_d   = tx_en_sig;
    tx_data_d = tx_data;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_count != '0) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        tx_data_d = mem[rd_ptr];
        tx_en_d   = 1'b1;
        pop       = 1'b1;
        state_d   = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_done_sig) begin
          tx_en_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        tx_en_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

`ifdef RX_OVERFLOW_CNT_EN
  // Saturating count of dropped bytes.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= 8'h00;
    end else if (drop && (ovf_cnt != 8'hFF)) begin
      ovf_cnt <= ovf_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rx_buffer_ctrl_module.sv
// Scoreboard bench for rx_buffer_ctrl_module: stimulus pushes expected tx bytes,
// a monitor pops them on each tx_en_sig rising edge.
module tb_rx_buffer_ctrl_module;

  localparam int unsigned ADDR_W = 4;

  logic              sysclk;
  logic              rst_n;
  logic [7:0]        rx_data;
  logic              rx_done_sig;
  logic              rx_en_sig;
  logic [7:0]        tx_data;
  logic              tx_en_sig;
  logic              tx_done_sig;
  logic [ADDR_W:0]   fifo_count;
  logic              overflow;
`ifdef RX_OVERFLOW_CNT_EN
  logic [7:0]        ovf_cnt;
`endif

  int          n_tests;
  int          n_fail;
  int          n_rise;
  int          peak;
  int          base;
  logic        hold;
  logic        force_done;
  logic [7:0]  exp_q[$];

  rx_buffer_ctrl_module #(.ADDR_W(ADDR_W)) dut (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_done_sig (rx_done_sig),
    .rx_en_sig   (rx_en_sig),
    .tx_data     (tx_data),
    .tx_en_sig   (tx_en_sig),
    .tx_done_sig (tx_done_sig),
    .fifo_count  (fifo_count),
    .overflow    (overflow)
`ifdef RX_OVERFLOW_CNT_EN
    ,
    .ovf_cnt     (ovf_cnt)
`endif
  );

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transmit-stage model: one-cycle tx_done_sig per byte unless held off.
  initial begin
    tx_done_sig = 1'b0;
    forever begin
      @(negedge sysclk);
      tx_done_sig = force_done || (!hold && tx_en_sig && !tx_done_sig);
    end
  end

  // Monitor: pop the scoreboard on each new byte, check the byte stays stable.
  initial begin
    logic       prev_en;
    logic [7:0] held;
    logic [7:0] e;
    prev_en = 1'b0;
    held    = 8'h00;
    forever begin
      @(negedge sysclk);
      if (fifo_count > peak) peak = int'(fifo_count);
      if (tx_en_sig && !prev_en) begin
        n_rise++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_tx: got byte %0h, expected no transmission", tx_data);
        end else begin
          e = exp_q.pop_front();
          chk("tx_data", 32'(tx_data), 32'(e));
        end
        held = tx_data;
      end else if (tx_en_sig && prev_en) begin
        chk("tx_hold", 32'(tx_data), 32'(held));
      end
      prev_en = tx_en_sig;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  // Called at posedge+1; leaves rx_done_sig low, returns at posedge+1.
  task automatic send(input logic [7:0] b, input int hi, input bit expect_out);
    if (expect_out) exp_q.push_back(b);
    rx_data     = b;
    rx_done_sig = 1'b1;
    cyc(hi);
    rx_done_sig = 1'b0;
    cyc(1);
  endtask

  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge sysclk);
    chk({tag, "_tx_en"}, 32'(tx_en_sig), 32'd0);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'h00);
    chk({tag, "_count"}, 32'(fifo_count), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_rx_en"}, 32'(rx_en_sig), 32'd1);
`ifdef RX_OVERFLOW_CNT_EN
    chk({tag, "_ovf_cnt"}, 32'(ovf_cnt), 32'd0);
`endif
    @(posedge sysclk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (k < 400 && !(exp_q.size() == 0 && !tx_en_sig && fifo_count == '0)) begin
      cyc(1);
      k++;
    end
    chk(name, (k < 400) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    n_rise      = 0;
    peak        = 0;
    hold        = 1'b1;
    force_done  = 1'b0;
    rst_n       = 1'b0;
    rx_data     = 8'h00;
    rx_done_sig = 1'b0;
    cyc(1);
    reset_pulse("rst0");

    // Single byte: latency 2 cycles after the write, manual tx_done pulse.
    exp_q.push_back(8'hA5);
    rx_data     = 8'hA5;
    rx_done_sig = 1'b1;
    cyc(1);
    rx_done_sig = 1'b0;
    @(posedge sysclk);
    @(negedge sysclk);
    chk("single_count_w", 32'(fifo_count), 32'd1);
    chk("single_en_w", 32'(tx_en_sig), 32'd0);
    @(negedge sysclk);
    chk("single_en_w1", 32'(tx_en_sig), 32'd0);
    @(negedge sysclk);
    chk("single_en_w2", 32'(tx_en_sig), 32'd1);
    chk("single_data", 32'(tx_data), 32'hA5);
    chk("single_count_load", 32'(fifo_count), 32'd0);
    cyc(3);
    chk("single_wait_hold", 32'(tx_en_sig), 32'd1);
    force_done = 1'b1;
    cyc(1);
    force_done = 1'b0;
    @(negedge sysclk);
    chk("single_en_done", 32'(tx_en_sig), 32'd0);
    chk("single_count_done", 32'(fifo_count), 32'd0);
    cyc(1);
    drain("single_drain");

    // Held rx_done_sig stores a single byte.
    hold = 1'b0;
    peak = 0;
    base = n_rise;
    send(8'h3C, 5, 1'b1);
    drain("held_drain");
    chk("held_peak", 32'(peak), 32'd1);
    chk("held_tx_count", 32'(n_rise - base), 32'd1);

    // Fill with transmit stalled: 0x00 presented, 0x01..0x10 stored, 0x11 dropped.
    hold = 1'b1;
    peak = 0;
    for (int i = 0; i < 18; i++) send(8'(i), 1, (i < 17));
    cyc(3);
    @(negedge sysclk);
    chk("fill_count", 32'(fifo_count), 32'd16);
    chk("fill_rx_en", 32'(rx_en_sig), 32'd0);
    chk("fill_overflow", 32'(overflow), 32'd1);
    chk("fill_tx_en", 32'(tx_en_sig), 32'd1);
    chk("fill_tx_data", 32'(tx_data), 32'h00);
    chk("fill_peak", 32'(peak), 32'd16);
`ifdef RX_OVERFLOW_CNT_EN
    chk("fill_ovf_cnt", 32'(ovf_cnt), 32'd1);
`endif
    cyc(1);
    hold = 1'b0;
    drain("fill_drain");
    chk("fill_overflow_sticky", 32'(overflow), 32'd1);
    chk("fill_rx_en_after", 32'(rx_en_sig), 32'd1);

    // Write into a full FIFO in the same cycle as a LOAD pop.
    reset_pulse("rst1");
    hold = 1'b1;
    for (int i = 0; i < 17; i++) send(8'(8'h20 + i), 1, 1'b1);
    cyc(3);
    chk("sim_pre_count", 32'(fifo_count), 32'd16);
    chk("sim_pre_tx", 32'(tx_data), 32'h20);
    force_done = 1'b1;
    cyc(1);
    force_done = 1'b0;
    chk("sim_rx_en_full", 32'(rx_en_sig), 32'd0);
    exp_q.push_back(8'h77);
    rx_data     = 8'h77;
    rx_done_sig = 1'b1;
    cyc(1);
    rx_done_sig = 1'b0;
    cyc(1);
    chk("sim_count", 32'(fifo_count), 32'd16);
    chk("sim_overflow", 32'(overflow), 32'd0);
    chk("sim_tx_en", 32'(tx_en_sig), 32'd1);
    chk("sim_tx_data", 32'(tx_data), 32'h21);
`ifdef RX_OVERFLOW_CNT_EN
    chk("sim_ovf_cnt", 32'(ovf_cnt), 32'd0);
`endif
    hold = 1'b0;
    drain("sim_drain");
    chk("sim_overflow_end", 32'(overflow), 32'd0);

    // Reset during WAIT_DONE discards stored bytes.
    hold = 1'b1;
    send(8'h51, 1, 1'b1);
    send(8'h52, 1, 1'b1);
    send(8'h53, 1, 1'b1);
    cyc(3);
    chk("mid_tx_en", 32'(tx_en_sig), 32'd1);
    chk("mid_count", 32'(fifo_count), 32'd2);
    reset_pulse("rst_mid");
    hold = 1'b0;
    base = n_rise;
    cyc(10);
    chk("mid_no_tx", 32'(n_rise - base), 32'd0);
    chk("mid_count_after", 32'(fifo_count), 32'd0);
    send(8'h99, 1, 1'b1);
    drain("mid_new_drain");
    chk("mid_new_tx", 32'(n_rise - base), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
